// File: rtl/bp_me_clint_pkg.sv
// Shared definitions for the multi-hart CLINT.
//   - Address map constants: msip_base, mtimecmp_base, mtime_addr, hart_stride.
//   - clint_target_e: decoded target of a device-local access.
//   - expand_mask / merge_bytes: byte-lane write helpers.
package bp_me_clint_pkg;

  localparam logic [63:0] msip_base     = 64'h0000;
  localparam logic [63:0] mtimecmp_base = 64'h4000;
  localparam logic [63:0] mtime_addr    = 64'hBFF8;
  localparam int          hart_stride   = 8;

  // Each per-hart block spans 64 harts worth of 8-byte slots.
  localparam int hart_shift   = $clog2(hart_stride);
  localparam int region_shift = $clog2(hart_stride * 64);

  typedef enum logic [1:0] {
    e_clint_msip,
    e_clint_mtimecmp,
    e_clint_mtime,
    e_clint_none
  } clint_target_e;

  function automatic logic [63:0] expand_mask(input logic [7:0] mask);
    logic [63:0] m;
    for (int i = 0; i < 8; i++) m[8*i +: 8] = {8{mask[i]}};
    return m;
  endfunction

  function automatic logic [63:0] merge_bytes(input logic [63:0] old_val,
                                              input logic [63:0] data,
                                              input logic [7:0]  mask);
    logic [63:0] m;
    m = expand_mask(mask);
    return (old_val & ~m) | (data & m);
  endfunction

endpackage

// File: rtl/bp_me_clint_mtime.sv
// Shared mtime counter with a clock prescaler and a byte-masked load port.
// Ports:
//   clk_i, reset_i  clock, asynchronous active-high reset
//   w_v_i           load strobe (write wins over a same-cycle tick)
//   w_data_i        load data
//   w_mask_i        byte enables for the load
//   mtime_o         current mtime value
module bp_me_clint_mtime
  import bp_me_clint_pkg::*;
#(
  parameter int prescale_p = 1
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        w_v_i,
  input  logic [63:0] w_data_i,
  input  logic [7:0]  w_mask_i,
  output logic [63:0] mtime_o
);

  // prescale_p = 1 still needs a 1-bit counter; it sits at its terminal count 0.
  localparam int cnt_w_lp = (prescale_p > 1) ? $clog2(prescale_p) : 1;
  localparam logic [cnt_w_lp-1:0] term_lp = cnt_w_lp'(prescale_p - 1);

  logic [cnt_w_lp-1:0] r_cnt;
  logic [63:0]         r_mtime;
  logic                w_tick;

  assign w_tick  = (r_cnt == term_lp);
  assign mtime_o = r_mtime;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_cnt   <= '0;
      r_mtime <= '0;
    end else if (w_v_i) begin
      // A load restarts the prescale window and suppresses any tick.
      r_mtime <= merge_bytes(r_mtime, w_data_i, w_mask_i);
      r_cnt   <= '0;
    end else if (w_tick) begin
      r_mtime <= r_mtime + 64'd1;
      r_cnt   <= '0;
    end else begin
      r_cnt   <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/bp_me_clint_multi.sv
// Multi-hart core-local interruptor: shared mtime, per-hart mtimecmp/msip.
// Optional feature macro: BP_ME_CLINT_MTIME_WRITE_EN (mtime becomes writable).
// Ports:
//   clk_i, reset_i            clock, asynchronous active-high reset
//   cmd_v_i / cmd_ready_and_o command handshake
//   cmd_w_i, cmd_addr_i, cmd_data_i, cmd_mask_i  command payload
//   resp_v_o / resp_ready_and_i  response handshake, resp_data_o payload
//   software_irq_o            per-hart msip
//   timer_irq_o               per-hart registered (mtime >= mtimecmp)
// Handshake: a transfer happens on a channel in any cycle where its valid and
// ready are both high; the response register holds a single entry, so a new
// command is taken only when that entry is empty or being drained this cycle,
// and valid/data hold stable while the response waits.
module bp_me_clint_multi
  import bp_me_clint_pkg::*;
#(
  parameter int num_harts_p  = 4,
  parameter int addr_width_p = 16,
  parameter int prescale_p   = 1
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    cmd_v_i,
  output logic                    cmd_ready_and_o,
  input  logic                    cmd_w_i,
  input  logic [addr_width_p-1:0] cmd_addr_i,
  input  logic [63:0]             cmd_data_i,
  input  logic [7:0]              cmd_mask_i,
  output logic                    resp_v_o,
  input  logic                    resp_ready_and_i,
  output logic [63:0]             resp_data_o,
  output logic [num_harts_p-1:0]  software_irq_o,
  output logic [num_harts_p-1:0]  timer_irq_o
);

  logic [63:0]      w_word;
  logic [5:0]       w_hart;
  logic             w_hart_ok;
  clint_target_e    w_target;
  logic             w_accept;
  logic             w_wr;
  logic             w_mtime_w_v;
  logic [63:0]      w_mtime;
  logic [63:0]      w_rdata;

  logic                   r_resp_v;
  logic [63:0]            r_resp_data;
  logic [num_harts_p-1:0] r_msip;
  logic [num_harts_p-1:0] r_timer_irq;
  logic [63:0]            r_mtimecmp [num_harts_p];

  assign cmd_ready_and_o = ~r_resp_v | resp_ready_and_i;
  assign w_accept        = cmd_v_i & cmd_ready_and_o;
  assign w_wr            = w_accept & cmd_w_i;

  // Decode: the low 3 address bits are dropped by the region/slot compares.
  always_comb begin
    w_word    = 64'(cmd_addr_i);
    w_hart    = w_word[hart_shift +: 6];
    w_hart_ok = (7'(w_hart) < 7'(num_harts_p));
    if (((w_word >> region_shift) == (msip_base >> region_shift)) && w_hart_ok)
      w_target = e_clint_msip;
    else if (((w_word >> region_shift) == (mtimecmp_base >> region_shift)) && w_hart_ok)
      w_target = e_clint_mtimecmp;
    else if ((w_word >> hart_shift) == (mtime_addr >> hart_shift))
      w_target = e_clint_mtime;
    else
      w_target = e_clint_none;
  end

`ifdef BP_ME_CLINT_MTIME_WRITE_EN
  assign w_mtime_w_v = w_wr & (w_target == e_clint_mtime);
`else
  assign w_mtime_w_v = 1'b0;
`endif

  bp_me_clint_mtime #(
    .prescale_p (prescale_p)
  ) u_mtime (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .w_v_i    (w_mtime_w_v),
    .w_data_i (cmd_data_i),
    .w_mask_i (cmd_mask_i),
    .mtime_o  (w_mtime)
  );

  // Read data is the pre-edge register value, so a same-cycle tick is not seen.
  always_comb begin
    w_rdata = '0;
    for (int h = 0; h < num_harts_p; h++) begin
      if (w_hart == 6'(h)) begin
        if (w_target == e_clint_msip)          w_rdata = {63'b0, r_msip[h]};
        else if (w_target == e_clint_mtimecmp) w_rdata = r_mtimecmp[h];
      end
    end
    if (w_target == e_clint_mtime) w_rdata = w_mtime;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_msip      <= '0;
      r_timer_irq <= '0;
      for (int h = 0; h < num_harts_p; h++) r_mtimecmp[h] <= '1;
    end else begin
      for (int h = 0; h < num_harts_p; h++) begin
        // Compares this cycle's values, giving the documented 1-cycle lag.
        r_timer_irq[h] <= (w_mtime >= r_mtimecmp[h]);
        if (w_wr && (w_hart == 6'(h))) begin
          if ((w_target == e_clint_msip) && cmd_mask_i[0])
            r_msip[h] <= cmd_data_i[0];
          if (w_target == e_clint_mtimecmp)
            r_mtimecmp[h] <= merge_bytes(r_mtimecmp[h], cmd_data_i, cmd_mask_i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_resp_v    <= 1'b0;
      r_resp_data <= '0;
    end else if (w_accept) begin
      r_resp_v    <= 1'b1;
      r_resp_data <= cmd_w_i ? 64'd0 : w_rdata;
    end else if (resp_ready_and_i) begin
      r_resp_v    <= 1'b0;
    end
  end

  assign resp_v_o       = r_resp_v;
  assign resp_data_o    = r_resp_data;
  assign software_irq_o = r_msip;
  assign timer_irq_o    = r_timer_irq;

endmodule

// File: tb/tb_bp_me_clint_multi.sv
// Bench for bp_me_clint_multi with 4 harts and a prescaler of 4.
// Responses are matched against an expected queue by a separate monitor.
module tb_bp_me_clint_multi;

  localparam int NH = 4;
  localparam int AW = 16;
  localparam int PS = 4;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic          cmd_v_i = 1'b0;
  logic          cmd_ready_and_o;
  logic          cmd_w_i = 1'b0;
  logic [AW-1:0] cmd_addr_i = '0;
  logic [63:0]   cmd_data_i = '0;
  logic [7:0]    cmd_mask_i = '0;
  logic          resp_v_o;
  logic          resp_ready_and_i = 1'b1;
  logic [63:0]   resp_data_o;
  logic [NH-1:0] software_irq_o;
  logic [NH-1:0] timer_irq_o;

  int checks = 0;
  int errors = 0;
  int cyc;

  logic [63:0] exp_q[$];
  string       name_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk_i = ~clk_i;

  // Rising edges seen with reset released; with prescale 4, mtime = cyc/4.
  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  bp_me_clint_multi #(
    .num_harts_p  (NH),
    .addr_width_p (AW),
    .prescale_p   (PS)
  ) dut (
    .clk_i            (clk_i),
    .reset_i          (reset_i),
    .cmd_v_i          (cmd_v_i),
    .cmd_ready_and_o  (cmd_ready_and_o),
    .cmd_w_i          (cmd_w_i),
    .cmd_addr_i       (cmd_addr_i),
    .cmd_data_i       (cmd_data_i),
    .cmd_mask_i       (cmd_mask_i),
    .resp_v_o         (resp_v_o),
    .resp_ready_and_i (resp_ready_and_i),
    .resp_data_o      (resp_data_o),
    .software_irq_o   (software_irq_o),
    .timer_irq_o      (timer_irq_o)
  );

  // ---------------- checking helpers ----------------
  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a falling edge; returns at the falling edge after acceptance.
  task automatic send(input logic w, input logic [15:0] a, input logic [63:0] d,
                      input logic [7:0] m, input logic [63:0] e, input string nm);
    int t;
    t = 0;
    while (!cmd_ready_and_o && t < 20) begin
      @(negedge clk_i);
      t++;
    end
    check({nm, "_ready"}, 64'(cmd_ready_and_o), 64'd1);
    cmd_v_i    = 1'b1;
    cmd_w_i    = w;
    cmd_addr_i = a;
    cmd_data_i = d;
    cmd_mask_i = m;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk_i);
    cmd_v_i = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [63:0] e;
    string       n;
    forever begin
      @(negedge clk_i);
      #1;
      if (!reset_i && resp_v_o && resp_ready_and_i) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp: got %h expected none", resp_data_o);
        end else begin
          e = exp_q.pop_front();
          n = name_q.pop_front();
          check(n, resp_data_o, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int t;
    repeat (3) @(negedge clk_i);
    check("rst_resp_v",    64'(resp_v_o),       64'd0);
    check("rst_resp_data", resp_data_o,         64'd0);
    check("rst_timer_irq", 64'(timer_irq_o),    64'd0);
    check("rst_sw_irq",    64'(software_irq_o), 64'd0);
    reset_i = 1'b0;

    // mtimecmp reset value and idle interrupt state
    send(1'b0, 16'h4008, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFF, "rd_mtimecmp1_rst");
    check("timer_irq_idle", 64'(timer_irq_o), 64'd0);

    // prescaled mtime: at cyc 40 the value is 10, then steps every 4 cycles
    t = 0;
    while (cyc < 40 && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    check("reach_cyc40", 64'(cyc), 64'd40);
    send(1'b0, 16'hBFF8, 64'd0, 8'h00, 64'd10, "rd_mtime_40");
    for (int i = 0; i < 4; i++)
      send(1'b0, 16'hBFF8, 64'd0, 8'h00, 64'(cyc / 4), "rd_mtime_window");

    // msip: mask bit 0 gates, unmapped hart dropped, only bit 0 stored
    send(1'b1, 16'h0000, 64'd1, 8'h01, 64'd0, "wr_msip0");
    check("sw_irq_set0", 64'(software_irq_o), 64'h1);
    send(1'b1, 16'h0000, 64'd0, 8'h02, 64'd0, "wr_msip0_nomask");
    check("sw_irq_nomask", 64'(software_irq_o), 64'h1);
    send(1'b1, 16'h0018, 64'd1, 8'h01, 64'd0, "wr_msip3");
    check("sw_irq_set3", 64'(software_irq_o), 64'h9);
    send(1'b1, 16'h0020, 64'd1, 8'hFF, 64'd0, "wr_msip4_unmapped");
    check("sw_irq_unmapped", 64'(software_irq_o), 64'h9);
    send(1'b0, 16'h0020, 64'd0, 8'h00, 64'd0, "rd_msip4_unmapped");
    send(1'b1, 16'h0008, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, "wr_msip1_ones");
    check("sw_irq_set1", 64'(software_irq_o), 64'hB);
    send(1'b0, 16'h0008, 64'd0, 8'h00, 64'd1, "rd_msip1");
    send(1'b0, 16'h0018, 64'd0, 8'h00, 64'd1, "rd_msip3");
    send(1'b0, 16'h1234, 64'd0, 8'h00, 64'd0, "rd_unmapped");

    // byte-lane merge on mtimecmp[1]
    send(1'b1, 16'h4008, 64'h1122_3344_5566_7788, 8'hFF, 64'd0, "wr_cmp1_full");
    send(1'b1, 16'h400C, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 64'd0, "wr_cmp1_low");
    send(1'b0, 16'h4008, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, "rd_cmp1_merged");

    // timer irq for hart 2 follows mtime == 20 by exactly one cycle
    send(1'b1, 16'h4010, 64'd20, 8'hFF, 64'd0, "wr_cmp2_20");
    t = 0;
    while (cyc < 80 && t < 200) begin
      @(negedge clk_i);
      t++;
    end
    check("reach_cyc80", 64'(cyc), 64'd80);
    check("timer_irq_at_20", 64'(timer_irq_o), 64'h0);
    @(negedge clk_i);
    check("timer_irq_lag", 64'(timer_irq_o), 64'h4);
    send(1'b1, 16'h4010, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 64'd0, "wr_cmp2_ones");
    check("timer_irq_hold", 64'(timer_irq_o), 64'h4);
    @(negedge clk_i);
    check("timer_irq_drop", 64'(timer_irq_o), 64'h0);

    // response held under backpressure
    resp_ready_and_i = 1'b0;
    send(1'b0, 16'h4008, 64'd0, 8'h00, 64'h1122_3344_AAAA_AAAA, "rd_stalled");
    for (int i = 0; i < 5; i++) begin
      check("stall_resp_v",    64'(resp_v_o),        64'd1);
      check("stall_resp_data", resp_data_o,          64'h1122_3344_AAAA_AAAA);
      check("stall_cmd_ready", 64'(cmd_ready_and_o), 64'd0);
      @(negedge clk_i);
    end
    resp_ready_and_i = 1'b1;
    @(negedge clk_i);

`ifdef BP_ME_CLINT_MTIME_WRITE_EN
    // load mtime near the top; it wraps after two ticks
    send(1'b1, 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF, 64'd0, "wr_mtime_top");
    check("wrap_irq_n0", 64'(timer_irq_o), 64'h0);
    @(negedge clk_i);
    check("wrap_irq_n1", 64'(timer_irq_o), 64'h2);
    send(1'b0, 16'hBFF8, 64'd0, 8'h00, 64'hFFFF_FFFF_FFFF_FFFE, "rd_mtime_top");
    repeat (2) @(negedge clk_i);
    check("wrap_irq_n4", 64'(timer_irq_o), 64'h2);
    @(negedge clk_i);
    check("wrap_irq_n5", 64'(timer_irq_o), 64'hF);
    repeat (3) @(negedge clk_i);
    send(1'b0, 16'hBFF8, 64'd0, 8'h00, 64'd0, "rd_mtime_wrapped");
    check("wrap_irq_n9", 64'(timer_irq_o), 64'h0);
`else
    // mtime is read-only: the write is acknowledged but has no effect
    send(1'b1, 16'hBFF8, 64'd5, 8'hFF, 64'd0, "wr_mtime_dropped");
    send(1'b0, 16'hBFF8, 64'd0, 8'h00, 64'(cyc / 4), "rd_mtime_after_wr");
`endif

    repeat (3) @(negedge clk_i);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
